axi4_frame_writer: RTL and testbench
====================================

// Module: axi4_frame_writer
// PURPOSE
//  AXI4 write master that stores a camera/pattern pixel stream (64-bit words, 4 x RGB565) into a DDR frame buffer.
//  Incoming words are buffered in an internal synchronous FIFO. Each full 64-beat burst (512 B) is written to DDR.
//  Sits in the PL between the pixel source and the PS HP port. Mirrors the HDMI read path, which fetches the frame back out.
//  On frame completion it toggles buf_select so the read path swaps buffers.
// PARAMETERS
//  AXI_ADDR_WIDTH    32    address width
//  AXI_DATA_WIDTH    64    data width (WSTRB = AXI_DATA_WIDTH/8 bits)
//  BURST_LEN         64    beats per burst; AWLEN = BURST_LEN-1
//  BURSTS_PER_FRAME  300   bursts per frame (320x240x2 B / 512 B)
//  FIFO_DEPTH        256   words in internal FIFO (power of 2, >= 2*BURST_LEN)
// PORTS
//  clk_100Mhz       in   1    sole clock (AXI and stream)
//  rst              in   1    synchronous, active-high reset
//  s_data           in   64   pixel word from source
//  s_valid          in   1    s_data valid
//  s_ready          out  1    = !fifo_full; a word is taken when s_valid && s_ready
//  frame_start      in   1    1-cycle pulse: next word begins a new frame
//  FRAME_BASE_ADDR  in   32   base address of the target buffer, sampled in IDLE
//  buf_select       out  1    toggles once per completed frame
//  frame_done       out  1    1-cycle pulse on the last B handshake of a frame
//  AWADDR/AWVALID/AWREADY, AWLEN(8)=BURST_LEN-1, AWSIZE(3)=3'b011, AWBURST(2)=2'b01, AWCACHE(4)=4'b0011
//  WDATA(64), WSTRB(8)=8'hFF, WVALID, WREADY, WLAST
//  BVALID, BREADY, BRESP(2)
//  bresp_err        out  1    sticky: set by any BRESP != 2'b00; cleared only by rst
//  state            out  2    debug: FSM state
//  ADDR_OFFSET      out  32   debug: byte offset of the next burst
// BEHAVIOUR
//  Reset: state=IDLE; AWVALID, WVALID, BREADY, frame_done, buf_select and bresp_err = 0; ADDR_OFFSET=0; burst_cnt=0; FIFO empty; armed=0; start_pend=0.
//  FIFO: FWFT. Push on s_valid && s_ready. Pop on WVALID && WREADY. Push and pop in the same cycle leave the count unchanged.
//  frame_start sets start_pend. start_pend is applied only on an IDLE cycle: ADDR_OFFSET=0, burst_cnt=0, armed=1, start_pend=0.
//  A burst in flight is never aborted. FIFO contents are never flushed. The source must deliver whole frames.
//  FSM:
//   IDLE: if start_pend, apply it and stay in IDLE this cycle.
//         Else if armed && fifo_count >= BURST_LEN: AWADDR <= FRAME_BASE_ADDR + ADDR_OFFSET, go to ADDR_SEND.
//   ADDR_SEND: AWVALID=1 until AWVALID && AWREADY. Drop AWVALID in the cycle after the handshake, then go to DATA_WRITE.
//              AWADDR is stable while AWVALID=1.
//   DATA_WRITE: WVALID = !fifo_empty. WDATA = FIFO head. beat_cnt increments per W handshake.
//               WLAST = (beat_cnt == BURST_LEN-1) && WVALID.
//               On the WLAST handshake: WVALID=0, go to RESP_WAIT. W is never issued before the AW handshake.
//   RESP_WAIT: BREADY=1. On BVALID && BREADY:
//               BREADY=0; ADDR_OFFSET += BURST_LEN*8; burst_cnt++; set bresp_err if BRESP != 0.
//               If burst_cnt was BURSTS_PER_FRAME-1: frame_done=1 for one cycle, buf_select toggles, ADDR_OFFSET=0, armed=0.
//               Return to IDLE.
//  Only one outstanding transaction at a time. Minimum 1 IDLE cycle between bursts.
//  ADDR_OFFSET arithmetic is 32-bit unsigned, max (BURSTS_PER_FRAME-1)*512. It must never reach BURSTS_PER_FRAME*512.
//  frame_start while armed (frame overrun) is applied at the next IDLE. The partial frame is abandoned: no frame_done, no toggle.
//  rst mid-burst returns to the reset state immediately, even with AXI handshakes open. The interconnect is reset alongside.
// TESTING
//  1. Reset, frame_start, push 64 words 0..63, AWREADY/WREADY/BVALID always 1
//     -> one AW at BASE+0 with AWLEN=63; 64 W beats with WLAST on beat 63; ADDR_OFFSET=512.
//  2. Full frame of 19200 words -> 300 bursts at BASE+0..BASE+153088; one frame_done pulse; buf_select 0->1; FSM parks in IDLE.
//  3. AWREADY held low 10 cycles; WREADY toggles 1,0 -> AWADDR/AWVALID stable; no W before the AW handshake; data order preserved.
//  4. FIFO fills with s_valid held high and WREADY=0 -> s_ready=0 at 256 words; no word lost or duplicated after WREADY=1.
//  5. BRESP=2'b10 on burst 5 -> bresp_err=1 and sticky; following bursts continue at the correct addresses.
//  6. frame_start during DATA_WRITE of burst 10 -> the burst completes; the next AWADDR=BASE+0; no frame_done; buf_select unchanged.

Source files
------------

// File: rtl/axi4_frame_writer.sv
// axi4_frame_writer: buffers a 64-bit pixel stream in a FWFT FIFO and writes it to a DDR frame buffer as fixed-length AXI4 bursts.
module axi4_frame_writer #(
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int AXI_DATA_WIDTH   = 64,
  parameter int BURST_LEN        = 64,
  parameter int BURSTS_PER_FRAME = 300,
  parameter int FIFO_DEPTH       = 256
) (
  input  logic                        clk_100Mhz,
  input  logic                        rst,
  input  logic [AXI_DATA_WIDTH-1:0]   s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic                        frame_start,
  input  logic [AXI_ADDR_WIDTH-1:0]   FRAME_BASE_ADDR,
  output logic                        buf_select,
  output logic                        frame_done,
  output logic [AXI_ADDR_WIDTH-1:0]   AWADDR,
  output logic                        AWVALID,
  input  logic                        AWREADY,
  output logic [7:0]                  AWLEN,
  output logic [2:0]                  AWSIZE,
  output logic [1:0]                  AWBURST,
  output logic [3:0]                  AWCACHE,
  output logic [AXI_DATA_WIDTH-1:0]   WDATA,
  output logic [AXI_DATA_WIDTH/8-1:0] WSTRB,
  output logic                        WVALID,
  input  logic                        WREADY,
  output logic                        WLAST,
  input  logic                        BVALID,
  output logic                        BREADY,
  input  logic [1:0]                  BRESP,
  output logic                        bresp_err,
  output logic [1:0]                  state,
  output logic [AXI_ADDR_WIDTH-1:0]   ADDR_OFFSET
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(BURST_LEN);
  localparam int CW = $clog2(BURSTS_PER_FRAME);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] LEN = (AW+1)'(BURST_LEN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN-1);
  localparam logic [CW-1:0] LAST_BURST = CW'(BURSTS_PER_FRAME-1);
  localparam logic [AXI_ADDR_WIDTH-1:0] STEP = AXI_ADDR_WIDTH'(BURST_LEN*AXI_DATA_WIDTH/8);
  typedef enum logic [1:0] {IDLE, ADDR_SEND, DATA_WRITE, RESP_WAIT} state_t;
  state_t cur, nxt;
  logic [AXI_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [BW-1:0] beat_cnt;
  logic [CW-1:0] burst_cnt;
  logic armed, start_pend, push, pop, last_burst;
  assign state = cur;
  assign s_ready = count != DEPTH;
  assign push = s_valid && s_ready;
  assign pop = WVALID && WREADY;
  assign last_burst = burst_cnt == LAST_BURST;
  assign AWVALID = cur == ADDR_SEND;
  assign AWLEN = 8'(BURST_LEN-1);
  assign AWSIZE = 3'($clog2(AXI_DATA_WIDTH/8));
  assign AWBURST = 2'b01;
  assign AWCACHE = 4'b0011;
  assign WDATA = mem[rd_ptr];
  assign WSTRB = '1;
  assign WVALID = cur == DATA_WRITE && count != '0;
  assign WLAST = WVALID && beat_cnt == LAST_BEAT;
  assign BREADY = cur == RESP_WAIT;
  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:       nxt = (!start_pend && armed && count >= LEN) ? ADDR_SEND : IDLE;
      ADDR_SEND:  nxt = AWREADY ? DATA_WRITE : ADDR_SEND;
      DATA_WRITE: nxt = (pop && WLAST) ? RESP_WAIT : DATA_WRITE;
      RESP_WAIT:  nxt = BVALID ? IDLE : RESP_WAIT;
      default:    nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_100Mhz)
    if (push) mem[wr_ptr] <= s_data;
  always_ff @(posedge clk_100Mhz) begin
    if (rst) begin
      cur         <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      beat_cnt    <= '0;
      burst_cnt   <= '0;
      armed       <= 1'b0;
      start_pend  <= 1'b0;
      ADDR_OFFSET <= '0;
      AWADDR      <= '0;
      frame_done  <= 1'b0;
      buf_select  <= 1'b0;
      bresp_err   <= 1'b0;
    end else begin
      cur        <= nxt;
      frame_done <= 1'b0;
      wr_ptr     <= wr_ptr + AW'(push);
      rd_ptr     <= rd_ptr + AW'(pop);
      count      <= count + (AW+1)'(push) - (AW+1)'(pop);
      beat_cnt   <= (cur != DATA_WRITE) ? '0 : beat_cnt + BW'(pop);
      // a pulse arriving on the applying cycle stays pending for the next IDLE
      start_pend <= frame_start || (start_pend && cur != IDLE);
      if (cur == IDLE && start_pend) begin
        ADDR_OFFSET <= '0;
        burst_cnt   <= '0;
        armed       <= 1'b1;
      end
      if (cur == IDLE && nxt == ADDR_SEND) AWADDR <= FRAME_BASE_ADDR + ADDR_OFFSET;
      if (BVALID && BREADY) begin
        bresp_err   <= bresp_err || BRESP != 2'b00;
        burst_cnt   <= last_burst ? '0 : burst_cnt + CW'(1);
        ADDR_OFFSET <= last_burst ? '0 : ADDR_OFFSET + STEP;
        if (last_burst) begin
          frame_done <= 1'b1;
          buf_select <= !buf_select;
          armed      <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_axi4_frame_writer.sv
// tb_axi4_frame_writer: scoreboard bench for axi4_frame_writer with a reactive AXI slave.
module tb_axi4_frame_writer;
  logic clk_100Mhz = 1'b0, rst = 1'b1;
  logic [63:0] s_data = '0;
  logic s_valid = 1'b0, s_ready, frame_start = 1'b0;
  logic [31:0] FRAME_BASE_ADDR = 32'h1000_0000;
  logic buf_select, frame_done, AWVALID, WVALID, WLAST, BREADY, bresp_err;
  logic AWREADY = 1'b1, WREADY = 1'b1, BVALID = 1'b1;
  logic [1:0] BRESP = 2'b00, AWBURST, state;
  logic [31:0] AWADDR, ADDR_OFFSET;
  logic [7:0] AWLEN, WSTRB;
  logic [2:0] AWSIZE;
  logic [3:0] AWCACHE;
  logic [63:0] WDATA;
  axi4_frame_writer dut (
    .clk_100Mhz(clk_100Mhz), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .frame_start(frame_start), .FRAME_BASE_ADDR(FRAME_BASE_ADDR), .buf_select(buf_select),
    .frame_done(frame_done), .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY), .AWLEN(AWLEN),
    .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWCACHE(AWCACHE), .WDATA(WDATA), .WSTRB(WSTRB),
    .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST), .BVALID(BVALID), .BREADY(BREADY),
    .BRESP(BRESP), .bresp_err(bresp_err), .state(state), .ADDR_OFFSET(ADDR_OFFSET)
  );
  always #5 clk_100Mhz = ~clk_100Mhz;
  int vectors = 0, errors = 0, seq = 0;
  logic [63:0] exp_w[$];
  logic [31:0] exp_aw[$];
  int model_word = 0, exp_frames = 0, aw_cnt = 0, b_cnt = 0, done_cnt = 0, beats = 0;
  bit aw_open = 0, aw_wait = 0, aw_hs = 0;
  logic [31:0] aw_hold = '0;
  int aw_stall = 0, stall_ctr = 0, err_idx = -1;
  bit w_toggle = 0, w_block = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  endtask
  // monitor and scoreboard, sampled on the falling edge
  always @(negedge clk_100Mhz) begin
    if (!rst) begin
      if (frame_start) model_word = 0;
      if (s_valid && s_ready) begin
        exp_w.push_back(s_data);
        if (model_word % 64 == 63) exp_aw.push_back(FRAME_BASE_ADDR + 32'(model_word / 64) * 32'd512);
        model_word++;
        if (model_word == 19200) exp_frames++;
      end
      if (aw_wait) begin
        chk("awaddr_stable", 64'(AWADDR), 64'(aw_hold));
        chk("awvalid_stable", 64'(AWVALID), 64'd1);
      end
      aw_wait = AWVALID && !AWREADY;
      aw_hold = AWADDR;
      aw_hs = AWVALID && AWREADY;
      if (WVALID) chk("w_before_aw", 64'(aw_open), 64'd1);
      if (aw_hs) begin
        chk("aw_expected", 64'(exp_aw.size() != 0), 64'd1);
        if (exp_aw.size() != 0) chk("awaddr", 64'(AWADDR), 64'(exp_aw.pop_front()));
        chk("awlen", 64'(AWLEN), 64'd63);
        chk("aw_attr", 64'({AWSIZE, AWBURST, AWCACHE}), 64'(9'b011_01_0011));
        aw_open = 1;
        beats = 0;
        aw_cnt++;
      end
      if (WVALID && WREADY) begin
        chk("w_expected", 64'(exp_w.size() != 0), 64'd1);
        if (exp_w.size() != 0) chk("wdata", WDATA, exp_w.pop_front());
        chk("wlast", 64'(WLAST), 64'(beats == 63));
        chk("wstrb", 64'(WSTRB), 64'hFF);
        beats++;
        if (WLAST) aw_open = 0;
      end
      if (BVALID && BREADY) b_cnt++;
      if (frame_done) begin
        done_cnt++;
        chk("buf_select_toggle", 64'(buf_select), 64'(done_cnt % 2));
      end
    end
  end
  // AXI slave, driven just after the rising edge
  always @(posedge clk_100Mhz) begin
    #1;
    stall_ctr = aw_hs ? 0 : AWVALID ? stall_ctr + 1 : stall_ctr;
    AWREADY = stall_ctr >= aw_stall;
    WREADY = w_block ? 1'b0 : w_toggle ? !WREADY : 1'b1;
    BRESP = (b_cnt == err_idx) ? 2'b10 : 2'b00;
  end
  task automatic push(input logic [63:0] d);
    int t = 0;
    s_data = d;
    s_valid = 1'b1;
    @(negedge clk_100Mhz);
    while (!s_ready && t < 2000) begin
      t++;
      @(negedge clk_100Mhz);
    end
    if (t >= 2000) begin
      chk("push_timeout", 64'(s_ready), 64'd1);
      finish_run();
    end
    @(posedge clk_100Mhz);
    #1;
    s_valid = 1'b0;
  endtask
  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      push(seq < 64 ? 64'(seq) : {$urandom, 32'(seq)});
      seq++;
    end
  endtask
  task automatic pulse_start();
    frame_start = 1'b1;
    @(posedge clk_100Mhz);
    #1;
    frame_start = 1'b0;
  endtask
  task automatic wait_b(input int n);
    int t = 0;
    while (b_cnt < n && t < 5000) begin
      t++;
      @(negedge clk_100Mhz);
    end
    chk("b_count", 64'(b_cnt), 64'(n));
    repeat (3) @(posedge clk_100Mhz);
    #1;
  endtask
  task automatic wait_aw_write(input int n);
    int t = 0;
    while (!(aw_cnt >= n && state == 2'd2) && t < 5000) begin
      t++;
      @(negedge clk_100Mhz);
    end
    chk("burst_in_write", 64'(aw_cnt >= n && state == 2'd2), 64'd1);
    @(posedge clk_100Mhz);
    #1;
  endtask
  initial begin
    #900000;
    chk("watchdog_b_count", 64'(b_cnt), 64'd312);
    finish_run();
  end
  initial begin
    repeat (3) @(posedge clk_100Mhz);
    @(negedge clk_100Mhz);
    chk("reset_ctrl", 64'({state, AWVALID, WVALID, BREADY, frame_done, buf_select, bresp_err}), 64'd0);
    chk("reset_offset", 64'(ADDR_OFFSET), 64'd0);
    chk("reset_s_ready", 64'(s_ready), 64'd1);
    @(posedge clk_100Mhz);
    #1;
    rst = 1'b0;
    pulse_start();
    push_n(64);
    wait_b(1);
    chk("single_burst_offset", 64'(ADDR_OFFSET), 64'd512);
    chk("single_burst_idle", 64'(state), 64'd0);
    aw_stall = 10;
    w_toggle = 1;
    push_n(64);
    wait_b(2);
    aw_stall = 0;
    w_toggle = 0;
    chk("stall_burst_offset", 64'(ADDR_OFFSET), 64'd1024);
    chk("bresp_err_clear", 64'(bresp_err), 64'd0);
    err_idx = 5;
    w_block = 1;
    push_n(256);
    s_data = {32'hFFFF_FFFF, 32'(seq)};
    s_valid = 1'b1;
    repeat (5) begin
      @(negedge clk_100Mhz);
      chk("fifo_full_s_ready", 64'(s_ready), 64'd0);
    end
    @(posedge clk_100Mhz);
    #1;
    s_valid = 1'b0;
    w_block = 0;
    push_n(64);
    wait_b(7);
    chk("bresp_err_set", 64'(bresp_err), 64'd1);
    push_n(19200 - 448);
    wait_b(300);
    chk("frame_done_count", 64'(done_cnt), 64'(exp_frames));
    chk("frame_buf_select", 64'(buf_select), 64'd1);
    chk("frame_offset_wrap", 64'(ADDR_OFFSET), 64'd0);
    chk("frame_parked_idle", 64'(state), 64'd0);
    FRAME_BASE_ADDR = 32'h2000_0000;
    pulse_start();
    push_n(704);
    wait_aw_write(311);
    pulse_start();
    push_n(64);
    wait_b(312);
    chk("overrun_offset", 64'(ADDR_OFFSET), 64'd512);
    chk("overrun_no_done", 64'(done_cnt), 64'd1);
    chk("overrun_buf_select", 64'(buf_select), 64'd1);
    chk("bresp_err_sticky", 64'(bresp_err), 64'd1);
    chk("aw_queue_drained", 64'(exp_aw.size()), 64'd0);
    chk("w_queue_drained", 64'(exp_w.size()), 64'd0);
    finish_run();
  end
endmodule
